// File: rtl/adc_ets_sampler_if.sv
// Phase-result stream from adc_ets_sampler to the capture/readout logic.
//   out_data  : phase sum (ACC_W bits)
//   out_phase : phase index of out_data (PH_W bits)
//   out_valid : out_data/out_phase valid, held until accepted
//   out_ready : consumer accepts when out_valid & out_ready
// master = producer (sampler), slave = consumer.
interface adc_ets_sampler_if #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned PH_W  = 3
) ();
  logic [ACC_W-1:0] out_data;
  logic [PH_W-1:0]  out_phase;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_phase, output out_valid, input out_ready);
  modport slave  (input out_data, input out_phase, input out_valid, output out_ready);
endinterface

// File: rtl/adc_ets_sampler.sv
// Equivalent-time ADC front end. Divides clk into the ADC conversion clock, waits a settling
// interval, then sweeps NUM_PHASES capture phases; each phase samples bn at a delay one
// DELAY_STEP earlier than the previous one, sums SAMPLES_PER_PHASE samples and hands the sum
// out over a valid/ready stream.
//   clk, rst : system clock, synchronous active-high reset
//   en       : enables divider and FSM; low aborts any operation
//   start    : one-cycle sweep request, honoured only when idle
//   bn       : ADC output data (unsigned)
//   adc_clk  : registered divided conversion clock
//   trigger  : one-cycle pulse after a sweep completes
//   busy     : FSM not idle
//   overrun  : sticky, an unaccepted phase result was overwritten
//   res      : phase-result stream (out_data, out_phase, out_valid, out_ready)
module adc_ets_sampler #(
  parameter int unsigned DATA_W            = 14,
  parameter int unsigned DIV               = 20,
  parameter int unsigned SETTLE_CYCLES     = 100,
  parameter int unsigned NUM_PHASES        = 5,
  parameter int unsigned SAMPLES_PER_PHASE = 4,
  parameter int unsigned BASE_DELAY        = 19,
  parameter int unsigned DELAY_STEP        = 1,
  parameter bit          CONTINUOUS        = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [DATA_W-1:0] bn,
  output logic              adc_clk,
  output logic              trigger,
  output logic              busy,
  output logic              overrun,
  adc_ets_sampler_if.master res
);

  localparam int unsigned ACC_W = DATA_W + $clog2(SAMPLES_PER_PHASE);
  localparam int unsigned PH_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned SMP_W = $clog2(SAMPLES_PER_PHASE + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 2);

  if (DIV < 4 || (DIV % 2) != 0) begin : g_bad_div
    $error("DIV must be even and at least 4");
  end
  if (NUM_PHASES < 1) begin : g_bad_phases
    $error("NUM_PHASES must be at least 1");
  end
  if (SAMPLES_PER_PHASE < 1 || (SAMPLES_PER_PHASE & (SAMPLES_PER_PHASE - 1)) != 0)
  begin : g_bad_samples
    $error("SAMPLES_PER_PHASE must be a power of two");
  end
  if (BASE_DELAY > DIV - 1 ||
      int'(BASE_DELAY) - (int'(NUM_PHASES) - 1) * int'(DELAY_STEP) < 1) begin : g_bad_delay
    $error("capture delays must lie in 1..DIV-1 for every phase");
  end

  typedef enum logic [2:0] {StIdle, StSettle, StWaitEdge, StCapture, StDone} state_e;

  // Divider
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             adc_clk_q;
  logic             adc_edge;

  always_comb begin
    count_nxt = (count_q == CNT_W'(DIV - 1)) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      count_q   <= '0;
      adc_clk_q <= 1'b0;
    end else begin
      count_q   <= count_nxt;
      // High exactly while count is in the upper half of the period
      adc_clk_q <= (32'(count_nxt) >= HALF);
    end
  end

  // First cycle of the high half
  assign adc_edge = adc_clk_q && (count_q == CNT_W'(HALF));
  assign adc_clk  = adc_clk_q;

  // Sweep FSM
  state_e           state_q;
  logic [SET_W-1:0] settle_q;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] target;
  logic [SMP_W-1:0] samples_q;
  logic [PH_W-1:0]  phase_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] out_data_q;
  logic [PH_W-1:0]  out_phase_q;
  logic             out_valid_q;
  logic             trigger_q;
  logic             overrun_q;

  always_comb begin
    target  = CNT_W'(BASE_DELAY - 32'(phase_q) * DELAY_STEP);
    acc_sum = acc_q + ACC_W'(bn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      delay_q     <= '0;
      samples_q   <= '0;
      phase_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_phase_q <= '0;
      out_valid_q <= 1'b0;
      trigger_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (!en) begin
      // Abort: drop pending work and any unaccepted result, keep the overrun history
      state_q     <= StIdle;
      samples_q   <= '0;
      phase_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      trigger_q   <= 1'b0;
    end else begin
      trigger_q <= 1'b0;
      if (out_valid_q && res.out_ready) out_valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            settle_q <= '0;
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          if (32'(settle_q) + 32'd1 >= SETTLE_CYCLES) state_q <= StWaitEdge;
          else settle_q <= settle_q + 1'b1;
        end
        StWaitEdge: begin
          // The edge cycle itself counts as delay 0
          if (adc_edge) begin
            delay_q <= CNT_W'(1);
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (delay_q == target) begin
            if (32'(samples_q) + 32'd1 == SAMPLES_PER_PHASE) begin
              out_data_q  <= acc_sum;
              out_phase_q <= phase_q;
              out_valid_q <= 1'b1;
              if (out_valid_q && !res.out_ready) overrun_q <= 1'b1;
              acc_q     <= '0;
              samples_q <= '0;
              if (32'(phase_q) == NUM_PHASES - 1) begin
                phase_q <= '0;
                state_q <= StDone;
              end else begin
                phase_q <= phase_q + 1'b1;
                state_q <= StWaitEdge;
              end
            end else begin
              acc_q     <= acc_sum;
              samples_q <= samples_q + 1'b1;
              state_q   <= StWaitEdge;
            end
          end else begin
            delay_q <= delay_q + 1'b1;
          end
        end
        StDone: begin
          trigger_q <= 1'b1;
          state_q   <= CONTINUOUS ? StWaitEdge : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign res.out_data  = out_data_q;
  assign res.out_phase = out_phase_q;
  assign res.out_valid = out_valid_q;
  assign trigger       = trigger_q;
  assign busy          = (state_q != StIdle);
  assign overrun       = overrun_q;

endmodule

// File: doc/adc_ets_sampler.md
Name: adc_ets_sampler

Overview:
- Parametrised equivalent-time ADC front end. Replaces the fixed 10 MHz divider / five-slot sub-sampler.
- Generates the ADC conversion clock from clk, waits a settling interval, then captures bn over NUM_PHASES phases. Each phase samples at a capture delay one step earlier than the previous phase.
- Accumulates SAMPLES_PER_PHASE samples per phase and delivers each phase sum over a valid/ready handshake. Pulses trigger when a full sweep completes.
- Sits between the ADC data pins and the capture/readout logic.

Parameters:
- DATA_W, 14, ADC sample width.
- DIV, 20, adc_clk period in clk cycles. Must be even and ≥4. Low for DIV/2, high for DIV/2.
- SETTLE_CYCLES, 100, clk cycles after start before the first capture.
- NUM_PHASES, 5, number of sub-sampling phases per sweep. Must be ≥1.
- SAMPLES_PER_PHASE, 4, samples accumulated per phase. Must be a power of 2, ≥1.
- BASE_DELAY, 19, capture delay for phase 0, in clk cycles after the adc_clk rising edge.
- DELAY_STEP, 1, delay decrement per phase. Elaboration error unless BASE_DELAY−(NUM_PHASES−1)·DELAY_STEP ≥ 1 and BASE_DELAY ≤ DIV−1.
- CONTINUOUS, 0, selects sweep mode. 1: restart the sweep at phase 0 after trigger, without re-settling. 0: one sweep per start.
- ACC_W, DATA_W+log2(SAMPLES_PER_PHASE), derived accumulator width.
- PH_W, max(1, clog2(NUM_PHASES)), derived phase-index width.

Ports:
- clk, in, 1, system clock (200 MHz).
- rst, in, 1, synchronous, active-high reset.
- en, in, 1, enables the divider and FSM. Low aborts any operation.
- start, in, 1, single-cycle request to begin a sweep sequence. Honoured only in IDLE with en=1.
- bn, in, DATA_W, ADC output data, unsigned.
- adc_clk, out, 1, divided conversion clock (registered).
- out_data, out, ACC_W, phase sum.
- out_phase, out, PH_W, phase index of out_data.
- out_valid, out, 1, out_data/out_phase valid.
- out_ready, in, 1, consumer accepts when out_valid & out_ready.
- trigger, out, 1, one-cycle pulse at sweep completion.
- busy, out, 1, high in any state other than IDLE.
- overrun, out, 1, sticky flag: an unaccepted phase result was overwritten.

Behaviour:
- Reset values: adc_clk=0, out_data=0, out_phase=0, out_valid=0, trigger=0, busy=0, overrun=0. Divider count=0, FSM=IDLE, accumulator=0.
- Divider:
  - When en=0, count is held at 0 and adc_clk=0.
  - When en=1, count runs 0..DIV−1 and wraps.
  - adc_clk is registered high while count ∈ [DIV/2, DIV−1], so it is low for DIV/2 cycles and high for DIV/2 cycles.
  - "Edge cycle" is the first cycle in which adc_clk=1.
  - The divider free-runs whenever en=1, independent of FSM state.
- FSM states: IDLE, SETTLE, WAIT_EDGE, CAPTURE, DONE.
  - IDLE: start & en → SETTLE, with the settle counter cleared.
  - SETTLE: counts SETTLE_CYCLES clk cycles → WAIT_EDGE.
  - WAIT_EDGE: waits for the next edge cycle → CAPTURE, with the delay counter at 0 in the edge cycle.
  - CAPTURE: the delay counter increments every clk. In the cycle where delay == BASE_DELAY − phase·DELAY_STEP, bn is added to the accumulator (zero-extended to ACC_W) and the sample count increments.
    - If the sample count < SAMPLES_PER_PHASE → WAIT_EDGE.
    - If the phase is complete: the accumulator value is registered to out_data (a sample added in the same cycle is included), out_phase=phase, out_valid=1. The accumulator is cleared and the phase advances.
    - After the last phase → DONE. Otherwise → WAIT_EDGE.
  - DONE: trigger=1 for exactly one cycle.
    - CONTINUOUS=1 → WAIT_EDGE with phase 0.
    - CONTINUOUS=0 → IDLE.
- Capture rate: exactly one capture per adc_clk period. Capture latency after the edge cycle is the programmed delay.
- Handshake:
  - out_valid stays high until out_valid & out_ready.
  - If a new phase result completes while out_valid=1 and out_ready=0 in that cycle, the new result overwrites and overrun=1 (sticky until rst).
  - If out_ready=1 in the same cycle, there is no overrun.
- en=0 mid-operation:
  - FSM → IDLE; accumulator, sample count and phase cleared.
  - out_valid cleared, no trigger.
  - overrun retained.
- start while busy is ignored. rst overrides everything.
- The accumulator cannot overflow by construction (ACC_W).

Test Plan:
- rst, en=1, 40 cycles → adc_clk toggles with period 20 (10 low/10 high), all other outputs at reset values, busy=0.
- en=1, start pulse, bn held at 100, out_ready=1 → no capture before 100 cycles. Five results out_data=400, out_phase 0..4. trigger one cycle after phase-4 valid. busy falls. overrun=0.
- bn = free-running clk count (mod 2^14), out_ready=1 → consecutive phase sums differ by 4·(4·20−1)=316, confirming the per-phase delay steps 19,18,17,16,15.
- out_ready=0 for the whole sweep → overrun=1 at phase-1 completion. Final out_phase=4, out_valid held until out_ready asserts.
- CONTINUOUS=1, bn=7 → trigger repeats every 5·4·20=400 cycles after the first sweep, with no settle gap. out_data=28.
- en dropped during phase 2 → adc_clk=0, busy=0, out_valid=0, no trigger. A new start restarts at phase 0 after a full settle.
